// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
// State encoding, byte-enable constant and the request address check.
package dm_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } dm_state_e;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Misaligned byte address, or any bit set above the array's byte span.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/dm_ram_array.sv
// Word array with byte-enable write port, registered read port and async clear.
// Store tracing is compiled in only when DM_RESPONDER_TRACE_EN is defined.
module dm_ram_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              re_i,
    output logic [31:0]       rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [31:0] mem_q [Depth];
    logic [31:0] wr_word;

    // Read-modify-write merge so disabled lanes keep their old contents.
    always_comb begin
        wr_word = mem_q[addr_i];
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                wr_word[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wr_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

`ifdef DM_RESPONDER_TRACE_EN
    always @(posedge clk_i) begin
        if (rst_ni && we_i) begin
            $display("%0t @%0h: *%0h <= %08h", $time, {addr_i, 2'b00}, {addr_i, 2'b00}, wr_word);
        end
    end
`endif

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready load/store slave with WAIT_CYCLES wait states.
// Optional simulation trace when DM_RESPONDER_TRACE_EN is defined.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dm_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        err_q;
    logic        ld_q;
    logic        accept;
    logic        req_err;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    assign accept  = (state_q == StIdle) && req_valid;
    assign req_err = addr_err(req_addr, ADDR_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields and the error verdict are frozen at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= req_err;
            ld_q    <= !req_we && !req_err;
        end
    end

    assign ram_we = (state_q == StAccess) && we_q && !err_q;
    assign ram_re = (state_q == StAccess) && ld_q;

    dm_ram_array #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (ram_we),
        .be_i    (be_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    // The read register only updates on loads, so gating keeps stores/errors at zero.
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = err_q;
    assign rsp_rdata = ld_q ? ram_rdata : 32'd0;

`ifdef DM_RESPONDER_TRACE_EN
    logic [31:0] trace_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_addr_q <= '0;
        end else if (accept) begin
            trace_addr_q <= req_addr;
        end
    end

    always @(posedge clk) begin
        if (reset && (state_q == StAccess) && err_q) begin
            $display("%0t DM ERR @%08h", $time, trace_addr_q);
        end
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: reference memory model, latency and handshake checks.
module tb_dm_responder;
    import dm_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned WAIT   = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dm_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      rise;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    logic [31:0] model_mem [DEPTH];
    exp_t        sb [$];
    bit          in_resp = 0;
    bit          chk_idle = 0;
    bit          b2b_chk = 0;
    bit          have_last = 0;
    longint      last_acc = 0;
    logic [31:0] snap_rdata;
    logic        snap_err;
    int          rr_mode = 0;

    exp_t        cur;
    exp_t        nxt;
    longint      acc;
    int unsigned idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 32'd0;
        end
    endtask

    // Reset drops every pending transaction and clears the whole array.
    initial forever begin
        @(negedge reset);
        sb.delete();
        in_resp   = 0;
        chk_idle  = 0;
        have_last = 0;
        clear_model();
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor and acceptance-side scoreboard, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (chk_idle) begin
                check("idle_after_hs_ready", 64'(req_ready), 64'd1);
                check("idle_after_hs_valid", 64'(rsp_valid), 64'd0);
                chk_idle = 0;
            end
            if (rsp_valid && !in_resp) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_rsp actual=rsp_valid=1 expected=no response (cycle %0d)",
                             cyc);
                end else begin
                    cur = sb.pop_front();
                    check("rsp_latency", 64'(cyc), 64'(cur.rise));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(cur.err));
                end
                in_resp    = 1;
                snap_rdata = rsp_rdata;
                snap_err   = rsp_err;
            end else if (rsp_valid && in_resp) begin
                check("hold_rdata", 64'(rsp_rdata), 64'(snap_rdata));
                check("hold_err", 64'(rsp_err), 64'(snap_err));
                check("hold_req_ready", 64'(req_ready), 64'd0);
            end else if (in_resp && !rsp_valid) begin
                check("rsp_dropped", 64'(rsp_valid), 64'd1);
                in_resp = 0;
            end
            if (rsp_valid && rsp_ready) begin
                in_resp  = 0;
                chk_idle = 1;
            end
            if (req_valid && req_ready) begin
                acc       = cyc + 1;
                idx       = req_addr / 4;
                nxt.err   = (req_addr % 4 != 0) || (req_addr >= DEPTH * 4);
                nxt.rdata = 32'd0;
                nxt.rise  = acc + WAIT + 1;
                if (!nxt.err && req_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_be[b]) model_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else if (!nxt.err) begin
                    nxt.rdata = model_mem[idx];
                end
                if (b2b_chk && have_last) check("b2b_interval", 64'(acc - last_acc), 64'(WAIT + 3));
                last_acc  = acc;
                have_last = 1;
                sb.push_back(nxt);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        wait_ready();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_resp) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || in_resp) check("rsp_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    logic [31:0] a;
    int          n;

    initial begin
        #500000;
        $display("FAIL watchdog actual=still running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = BE_WORD;
        rsp_ready = 1'b1;
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'(req_ready), 64'd1);

        // Store then load, full word.
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, BE_WORD);
        wait_done();
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_done();

        // Byte-enable merge.
        issue(1'b1, 32'h20, 32'h1122_3344, BE_WORD);
        issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'h5);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_done();
        check("be_merge_model", 64'(model_mem[8]), 64'h11BB_33DD);

        // Errors: misaligned load, out-of-range store must not alias word 0.
        issue(1'b1, 32'h0, 32'hCAFE_F00D, BE_WORD);
        issue(1'b0, 32'h22, 32'h0, 4'h0);
        issue(1'b1, 32'h0000_1000, 32'h5555_AAAA, BE_WORD);
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        issue(1'b1, 32'h24, 32'h1234_0000, 4'h0);
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        wait_done();

        // Backpressure: RESP held for several cycles.
        rr_mode = 2;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_reached", 64'(rsp_valid), 64'd1);
        repeat (5) @(negedge clk);
        check("bp_valid_held", 64'(rsp_valid), 64'd1);
        rr_mode = 0;
        wait_done();

        // Reset during WAIT drops the store.
        issue(1'b1, 32'h30, 32'h1234_5678, BE_WORD);
        reset = 1'b0;
        #1;
        check("midop_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midop_req_ready", 64'(req_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_done();

        // Back-to-back with rsp_ready tied high: one transaction every WAIT+3 cycles.
        rr_mode   = 0;
        b2b_chk   = 1;
        have_last = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_we    = (k % 2 == 0);
            req_addr  = {22'd0, 4'(k / 2), 6'd0} | 32'h100;
            req_wdata = $urandom;
            req_be    = BE_WORD;
            wait_ready();
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_done();
        b2b_chk = 0;

        // Randomized traffic with random response backpressure.
        rr_mode = 1;
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 9))
                0:       a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                1:       a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
                2:       a = {20'd0, 10'($urandom), 2'b00};
                default: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            endcase
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        end
        rr_mode = 0;
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the slave end of the load/store request interface that the pipelined CPU's memory stage drives.
- Accepts one word request at a time over a valid/ready request channel.
- Inserts a parameterised number of wait states, then performs the access into an internal word array.
- Returns read data and an error flag over a valid/ready response channel. Lets the core be verified against a memory with realistic latency instead of a zero-latency array.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W 32-bit words (byte span 4*2**ADDR_W).
- WAIT_CYCLES, 1, wait states between request acceptance and the memory access; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, byte lanes aligned to the word.
- req_be  input  4  byte enables for stores; bit i enables wdata[8i+7:8i]; ignored for loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was out of range or misaligned.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset (reset=0), applied immediately and regardless of clk:
  - state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Every array word is cleared to 0.
  - req_ready follows state, so it reads 1, but no request is captured while reset=0.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0. On req_valid at an edge, latch we/addr/wdata/be and the error check. Next state is WAIT (counter=WAIT_CYCLES-1) if WAIT_CYCLES>0, else ACCESS.
  - WAIT: req_ready=0. Counter decrements each edge. At counter=0 the next state is ACCESS.
  - ACCESS: the single edge that commits the operation, then go to RESP.
    - Store without error: each enabled byte of word addr[ADDR_W+1:2] is written; disabled bytes are unchanged.
    - Load without error: rsp_rdata is registered from the array.
    - Error case: no write; rsp_rdata=0.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until a handshake edge (rsp_valid & rsp_ready), then go to IDLE with rsp_valid=0.
- Latency:
  - Request accepted at edge t0; rsp_valid rises after edge t0+WAIT_CYCLES+1.
  - Minimum cycles per transaction is WAIT_CYCLES+3: accept, WAIT_CYCLES waits, access, response handshake.
  - Requests are never accepted while busy, so there is no overlap.
- Error rule:
  - rsp_err=1 if req_addr[1:0]!=0 or req_addr[31:ADDR_W+2]!=0.
  - The check is evaluated at acceptance, and the array is untouched on error.
- Ordering: a load accepted after a store's response has completed returns the stored data (read-after-write is always visible).
- Response channel: rsp_ready held low keeps RESP with outputs frozen indefinitely. rsp_ready high while rsp_valid=0 has no effect.
- Reset mid-operation: any pending transaction is dropped without a response. A store whose ACCESS edge has not occurred is not committed.
- req_be=0 on a store: legal; a response is returned and memory is unchanged.

Optional Feature:
- Macro: DM_RESPONDER_TRACE_EN.
- Defined: at each committed store without error, simulation prints "@<byte addr hex>: *<byte addr hex> <= <merged word hex>" with time, using the post-merge word. Errors print "DM ERR @<addr hex>".
- Undefined: no display statements are compiled; functional behaviour is identical.

Decomposition:
- Shared package dm_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, RESP=2'd3;
  - byte-enable constant BE_WORD=4'hF;
  - function addr_err(addr, ADDR_W).
- One natural sub-module, dm_ram_array: a 2**ADDR_W x 32 word array with a byte-enable write port, a registered read port, and async active-low clear. The FSM and handshakes stay in dm_responder.

Test Plan:
- WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF, then load 0x10. Load returns 0xDEADBEEF with rsp_err=0; each rsp_valid rises exactly 3 edges after acceptance.
- Byte enables: store 0x11223344 to 0x20, then store 0xAABBCCDD with be 0x5, then load 0x20. Returns 0x11BB33DD.
- Error: load 0x22 returns rsp_err=1, rdata 0. Store to 0x00001000 with ADDR_W=10 returns rsp_err=1, and a subsequent load of 0x0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0 throughout; the handshake returns the block to IDLE on the next edge.
- Reset mid-op: accept a store 0x30←0x12345678 with WAIT_CYCLES=3, then pull reset low during WAIT. rsp_valid=0 immediately, no response is ever produced, and a later load 0x30 returns 0.
- WAIT_CYCLES=0: back-to-back stores/loads with rsp_ready tied 1. Exactly one transaction per 3 cycles, with data correct.
